riscv_reg_file: RTL and testbench

- RV32I integer register file: 32 architectural registers x0..x31, each 32 bits.
- Two combinational read ports (rs1/rs2) and one synchronous write port (rd).
- Sits between decode and execute in the core. x0 is hardwired to zero.
- Asynchronous active-low reset clears all registers.

---
 rtl/riscv_reg_file.sv | 65 ++++++
 tb/tb_riscv_reg_file.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_reg_file.sv
// RV32I integer register file: 2**ADDR_WIDTH entries of DATA_WIDTH bits,
// two combinational read ports and one synchronous write port.
// Register x0 always reads as zero and can never be written.
// When BYPASS=1, a same-cycle write to the read address is forwarded to the read port.
module riscv_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Entry 0 is cleared by reset and never written, so it stays zero.
  // Reads of x0 are also masked explicitly, so x0 reads as zero even if we is X.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr_valid;
  logic fwd1;
  logic fwd2;

  // A write is accepted only when we=1, outside reset, and the target is not x0.
  assign wr_valid = we && rst_n && (wa != '0);

  // Forwarding applies only in bypass builds and only for the register being written.
  assign fwd1 = BYPASS && wr_valid && (wa == ra1);
  assign fwd2 = BYPASS && wr_valid && (wa == ra2);

  // Storage: asynchronous clear, with writes on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // Read port 1: x0 reads as zero, otherwise the forwarded data or the stored entry.
  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      rd1 = fwd1 ? wd : mem[ra1];
    end
  end

  // Read port 2: same selection as port 1; it uses its own address independently.
  always_comb begin
    rd2 = '0;
    if (ra2 != '0) begin
      rd2 = fwd2 ? wd : mem[ra2];
    end
  end

endmodule

// File: tb/tb_riscv_reg_file.sv
// Directed testbench for riscv_reg_file.
// It instantiates one copy without bypass and one copy with bypass, and both share the same stimulus.
module tb_riscv_reg_file;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] rd1b;
  logic [31:0] rd2b;

  int vectors;
  int miscompares;

  riscv_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2)
  );

  riscv_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) dutb (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1b), .rd2(rd2b)
  );

  // 10 ns clock period; rising edges occur at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog that stops a runaway simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Write one register at the next rising edge; inputs change at the falling edge.
  task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1;
    wa = addr;
    wd = data;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  // Present read addresses and let the combinational outputs settle.
  task automatic setRead(input logic [4:0] a1, input logic [4:0] a2);
    ra1 = a1;
    ra2 = a2;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b1;
    we    = 1'b0;
    wa    = '0;
    wd    = '0;
    ra1   = '0;
    ra2   = '0;

    // Reset asserted mid-cycle; the reads must clear without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    setRead(5'd0, 5'd31);
    checkOutput("rst_rd1_x0", rd1, 32'h0);
    checkOutput("rst_rd2_x31", rd2, 32'h0);
    checkOutput("rst_b_rd2_x31", rd2b, 32'h0);

    // A write attempted while in reset is ignored and is not forwarded.
    we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF;
    setRead(5'd3, 5'd3);
    checkOutput("rst_b_nofwd", rd1b, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    setRead(5'd3, 5'd0);
    checkOutput("rst_wr_ignored", rd1, 32'h0);
    checkOutput("rst_b_wr_ignored", rd1b, 32'h0);

    // x0 cannot be written.
    applyStimulus(5'd0, 32'h1);
    setRead(5'd0, 5'd0);
    checkOutput("x0_rd1", rd1, 32'h0);
    checkOutput("x0_rd2", rd2, 32'h0);

    // Basic write and read.
    applyStimulus(5'd1, 32'h1);
    setRead(5'd1, 5'd0);
    checkOutput("x1_rd1", rd1, 32'h1);
    checkOutput("x1_rd2_x0", rd2, 32'h0);

    // we drops before the edge, so x2 is not written.
    @(negedge clk);
    we = 1'b1; wa = 5'd2; wd = 32'h2;
    #2;
    we = 1'b0;
    @(posedge clk);
    #1;
    setRead(5'd1, 5'd2);
    checkOutput("wegate_x1", rd1, 32'h1);
    checkOutput("wegate_x2", rd2, 32'h0);

    // Same-cycle read and write on x5: old value 0xA, new value 0xB.
    applyStimulus(5'd5, 32'hA);
    @(negedge clk);
    we = 1'b1; wa = 5'd5; wd = 32'hB;
    setRead(5'd5, 5'd1);
    checkOutput("rdw_nobyp", rd1, 32'hA);
    checkOutput("rdw_byp", rd1b, 32'hB);
    checkOutput("rdw_byp_other", rd2b, 32'h1);
    @(posedge clk);
    #1;
    we = 1'b0;
    checkOutput("rdw_after_nobyp", rd1, 32'hB);
    checkOutput("rdw_after_byp", rd1b, 32'hB);

    // x0 is never forwarded.
    @(negedge clk);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
    setRead(5'd0, 5'd5);
    checkOutput("x0_nofwd", rd1b, 32'h0);
    checkOutput("x0_nofwd_p2", rd2b, 32'hB);
    we = 1'b0;

    // A read-address change is visible without a clock edge.
    setRead(5'd1, 5'd1);
    checkOutput("async_addr_rd1", rd1, 32'h1);
    checkOutput("async_addr_rd2", rd2, 32'h1);
    setRead(5'd5, 5'd1);
    checkOutput("async_addr_chg", rd1, 32'hB);

    // Sweep: reset is asserted after x16 is written, and everything must be cleared.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(5'(i), 32'hC0DE0000 + 32'(i));
    end
    setRead(5'd16, 5'd15);
    checkOutput("sweep_x16_pre", rd1, 32'hC0DE0010);
    checkOutput("sweep_x15_pre", rd2, 32'hC0DE000F);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      setRead(5'(i), 5'(31 - i));
      checkOutput($sformatf("clr_rd1_x%0d", i), rd1, 32'h0);
      checkOutput($sformatf("clr_rd2_x%0d", 31 - i), rd2, 32'h0);
    end

    // Rewrite every register, then read back on both ports with mirrored addresses.
    for (int i = 1; i < 32; i++) begin
      applyStimulus(5'(i), 32'hC0DE0000 + 32'(i));
    end
    for (int i = 0; i < 32; i++) begin
      setRead(5'(i), 5'(31 - i));
      checkOutput($sformatf("full_rd1_x%0d", i), rd1,
                  (i == 0) ? 32'h0 : 32'hC0DE0000 + 32'(i));
      checkOutput($sformatf("full_rd2_x%0d", 31 - i), rd2,
                  (i == 31) ? 32'h0 : 32'hC0DE0000 + 32'(31 - i));
      checkOutput($sformatf("full_b_rd1_x%0d", i), rd1b,
                  (i == 0) ? 32'h0 : 32'hC0DE0000 + 32'(i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
